// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the M stage of a 5-stage MIPS pipeline.
// Holds SR/Cause/EPC/PRId, decides takes, and sequences the flush and the fetch redirect.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] PRID         = 32'h2020_0707
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_m,
    input  logic        m_valid,
    input  logic [4:0]  exccode_m,
    input  logic        bd_m,
    input  logic [5:0]  hwint,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic        eret_m,
    output logic [31:0] cp0_rdata,
    output logic        exc_req,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc_out
);

    localparam int CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_HANDLER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      sr_im_q, sr_im_d;
    logic            sr_exl_q, sr_exl_d;
    logic            sr_ie_q, sr_ie_d;
    logic            cause_bd_q, cause_bd_d;
    logic [5:0]      cause_ip_q, cause_ip_d;
    logic [4:0]      cause_exc_q, cause_exc_d;
    logic [31:0]     epc_q, epc_d;

    logic            int_take_s;
    logic            exc_take_s;
    logic            exc_req_s;
    logic            eret_take_s;
    logic            mtc0_s;
    logic            sr_wr_s;
    logic            epc_wr_s;

    // Return address: a delay-slot instruction restarts at its branch; word aligned, 32-bit wrap.
    function automatic logic [31:0] calc_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] base;
        base = bd ? (pc - 32'd4) : pc;
        return base & 32'hFFFF_FFFC;
    endfunction

    // Take decisions: only a real instruction in RUN with EXL clear can be interrupted.
    always_comb begin
        int_take_s  = (|(hwint & sr_im_q)) & sr_ie_q & ~sr_exl_q & m_valid & (state_q == ST_RUN);
        exc_take_s  = (exccode_m != 5'd0) & ~sr_exl_q & m_valid & (state_q == ST_RUN);
        exc_req_s   = int_take_s | exc_take_s;
        eret_take_s = eret_m & m_valid & sr_exl_q & (state_q != ST_FLUSH) & ~exc_req_s;
        mtc0_s      = cp0_we & m_valid & ~exc_req_s & (state_q != ST_FLUSH);
        sr_wr_s     = mtc0_s & (cp0_addr == REG_SR);
        epc_wr_s    = mtc0_s & (cp0_addr == REG_EPC);
    end

    // CP0 register next values; a take outranks eret and mtc0.
    always_comb begin
        cause_ip_d  = hwint;
        sr_im_d     = sr_wr_s ? cp0_wdata[15:10] : sr_im_q;
        sr_ie_d     = sr_wr_s ? cp0_wdata[0] : sr_ie_q;
        cause_bd_d  = exc_req_s ? bd_m : cause_bd_q;
        cause_exc_d = exc_req_s ? (int_take_s ? 5'd0 : exccode_m) : cause_exc_q;
        if (exc_req_s) begin
            sr_exl_d = 1'b1;
        end else if (eret_take_s) begin
            sr_exl_d = 1'b0;
        end else if (sr_wr_s) begin
            sr_exl_d = cp0_wdata[1];
        end else begin
            sr_exl_d = sr_exl_q;
        end
        if (exc_req_s) begin
            epc_d = calc_epc(pc_m, bd_m);
        end else if (epc_wr_s) begin
            epc_d = {cp0_wdata[31:2], 2'b00};
        end else begin
            epc_d = epc_q;
        end
    end

    // Pipeline sequencing FSM: RUN -> FLUSH (FLUSH_CYCLES-1 cycles) -> HANDLER -> RUN on eret.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_req_s) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_INIT;
            end else begin
                state_d = ST_HANDLER;
                cnt_d   = CNT_ZERO;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_HANDLER;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
                ST_HANDLER: begin
                    if (eret_take_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HANDLER;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Zero-latency pipeline controls: take and eret redirect in the same cycle they are seen.
    always_comb begin
        exc_req  = exc_req_s;
        redirect = exc_req_s | eret_take_s;
        flush    = exc_req_s | eret_take_s | (state_q == ST_FLUSH);
        epc_out  = epc_q;
        if (exc_req_s) begin
            redirect_pc = HANDLER_ADDR;
        end else if (eret_take_s) begin
            redirect_pc = epc_q;
        end else begin
            redirect_pc = 32'h0000_0000;
        end
    end

    // mfc0 read mux; unmapped registers read as zero.
    always_comb begin
        cp0_rdata = 32'h0000_0000;
        case (cp0_addr)
            REG_SR:    cp0_rdata = {16'h0000, sr_im_q, 8'h00, sr_exl_q, sr_ie_q};
            REG_CAUSE: cp0_rdata = {cause_bd_q, 15'h0000, cause_ip_q, 3'b000, cause_exc_q, 2'b00};
            REG_EPC:   cp0_rdata = epc_q;
            REG_PRID:  cp0_rdata = PRID;
            default:   cp0_rdata = 32'h0000_0000;
        endcase
    end

    // State and CP0 register flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= CNT_ZERO;
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios with constant expectations, then
// randomized traffic against a behavioural model of the CP0 rules.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] HANDLER_C = 32'h0000_4180;
    localparam logic [31:0] PRID_C    = 32'h2020_0707;
    localparam int          FC        = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_m;
    logic        m_valid;
    logic [4:0]  exccode_m;
    logic        bd_m;
    logic [5:0]  hwint;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        eret_m;
    logic [31:0] cp0_rdata;
    logic        exc_req;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc_out;

    int total = 0;
    int bad   = 0;

    // Model state: 0 = running, 1 = flushing, 2 = in handler
    logic [5:0]  m_im;
    logic        m_exl, m_ie, m_bd;
    logic [5:0]  m_ip;
    logic [4:0]  m_exc;
    logic [31:0] m_epc;
    int          m_mode, m_left;
    logic        e_req, e_int, e_eret, e_flush, e_redir;
    logic [31:0] e_rpc, e_rdata;

    cp0_exc_ctrl dut (
        .clk(clk), .reset_n(reset_n), .pc_m(pc_m), .m_valid(m_valid),
        .exccode_m(exccode_m), .bd_m(bd_m), .hwint(hwint), .cp0_we(cp0_we),
        .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .eret_m(eret_m),
        .cp0_rdata(cp0_rdata), .exc_req(exc_req), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic idle();
        pc_m = 32'h0; m_valid = 1'b0; exccode_m = 5'd0; bd_m = 1'b0; hwint = 6'd0;
        cp0_we = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'h0; eret_m = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_im = 6'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ip = 6'd0;
        m_exc = 5'd0; m_epc = 32'h0; m_mode = 0; m_left = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    task automatic model_comb();
        e_int   = m_valid && m_mode == 0 && !m_exl && m_ie && ((hwint & m_im) != 6'd0);
        e_req   = e_int || (m_valid && m_mode == 0 && !m_exl && exccode_m != 5'd0);
        e_eret  = !e_req && m_valid && eret_m && m_exl && m_mode != 1;
        e_flush = e_req || e_eret || m_mode == 1;
        e_redir = e_req || e_eret;
        e_rpc   = e_req ? HANDLER_C : (e_eret ? m_epc : 32'h0);
        case (cp0_addr)
            5'd12:   e_rdata = {16'h0, m_im, 8'h0, m_exl, m_ie};
            5'd13:   e_rdata = {m_bd, 15'h0, m_ip, 3'b0, m_exc, 2'b0};
            5'd14:   e_rdata = m_epc;
            5'd15:   e_rdata = PRID_C;
            default: e_rdata = 32'h0;
        endcase
    endtask

    task automatic model_clock();
        int old_mode;
        old_mode = m_mode;
        m_ip = hwint;
        if (e_req) begin
            m_exl = 1'b1;
            m_bd  = bd_m;
            m_exc = e_int ? 5'd0 : exccode_m;
            m_epc = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
            m_left = FC - 1;
            m_mode = (FC > 1) ? 1 : 2;
        end else begin
            if (old_mode == 1) begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = 2;
            end
            if (cp0_we && m_valid && old_mode != 1) begin
                if (cp0_addr == 5'd12) begin
                    m_im = cp0_wdata[15:10]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
                end
                if (cp0_addr == 5'd14) m_epc = cp0_wdata & 32'hFFFF_FFFC;
            end
            if (e_eret) begin
                m_exl  = 1'b0;
                m_mode = 0;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] want;
        do_reset();
        @(negedge clk);
        total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL rst_exc_req got %0b want 0", exc_req); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got %0b want 0", flush); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect got %0b want 0", redirect); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_redirect_pc got %h want 0", redirect_pc); end
        total++; if (epc_out !== 32'h0) begin bad++; $display("FAIL rst_epc got %h want 0", epc_out); end
        for (int a = 12; a <= 15; a++) begin
            cp0_addr = 5'(a);
            want = (a == 15) ? PRID_C : 32'h0;
            #1;
            total++; if (cp0_rdata !== want) begin bad++; $display("FAIL rst_rdata reg%0d got %h want %h", a, cp0_rdata, want); end
        end
        cyc();
    endtask

    task automatic test_exception_eret();
        idle(); pc_m = 32'h3008; exccode_m = 5'd10; m_valid = 1'b1;
        @(negedge clk);
        total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL ri_exc_req got %0b want 1", exc_req); end
        total++; if (redirect_pc !== HANDLER_C) begin bad++; $display("FAIL ri_redirect_pc got %h want %h", redirect_pc, HANDLER_C); end
        total++; if (flush !== 1'b1 || redirect !== 1'b1) begin bad++; $display("FAIL ri_flush_redir got %0b%0b want 11", flush, redirect); end
        cyc(); idle();
        @(negedge clk);
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL ri_flush2 got %0b want 1", flush); end
        total++; if (epc_out !== 32'h3008) begin bad++; $display("FAIL ri_epc got %h want 3008", epc_out); end
        cp0_addr = 5'd13; #1;
        total++; if (cp0_rdata !== 32'h28) begin bad++; $display("FAIL ri_cause got %h want 28", cp0_rdata); end
        cp0_addr = 5'd12; #1;
        total++; if (cp0_rdata !== 32'h2) begin bad++; $display("FAIL ri_sr got %h want 2", cp0_rdata); end
        cyc(); idle();
        @(negedge clk);
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL ri_flush3 got %0b want 0", flush); end
        m_valid = 1'b1; exccode_m = 5'd4; pc_m = 32'h4180; #1;
        total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL hdl_no_take got %0b want 0", exc_req); end
        cyc(); idle(); m_valid = 1'b1; eret_m = 1'b1;
        @(negedge clk);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h3008 || flush !== 1'b1) begin
            bad++; $display("FAIL eret_redirect got %0b %h %0b want 1 3008 1", redirect, redirect_pc, flush); end
        cyc(); idle(); cp0_addr = 5'd12;
        @(negedge clk);
        total++; if (cp0_rdata !== 32'h0 || flush !== 1'b0) begin bad++; $display("FAIL eret_after got sr=%h flush=%0b want 0 0", cp0_rdata, flush); end
        cyc();
    endtask

    task automatic test_interrupt();
        idle(); m_valid = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'h0000_0401;
        cyc(); idle(); cp0_addr = 5'd12;
        @(negedge clk);
        total++; if (cp0_rdata !== 32'h401) begin bad++; $display("FAIL int_sr got %h want 401", cp0_rdata); end
        hwint = 6'b000001; pc_m = 32'h3010; bd_m = 1'b1; m_valid = 1'b1; #1;
        total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL int_take got %0b want 1", exc_req); end
        cyc(); idle(); hwint = 6'b000001; cp0_addr = 5'd13;
        @(negedge clk);
        total++; if (cp0_rdata !== 32'h8000_0400) begin bad++; $display("FAIL int_cause got %h want 80000400", cp0_rdata); end
        total++; if (epc_out !== 32'h300C) begin bad++; $display("FAIL int_epc got %h want 300c", epc_out); end
        m_valid = 1'b1; exccode_m = 5'd4; #1;
        total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL flush_no_take got %0b want 0", exc_req); end
        cyc(); idle(); cyc();
        m_valid = 1'b1; eret_m = 1'b1;
        cyc(); idle();
    endtask

    task automatic test_priority_bubble();
        idle(); hwint = 6'b000001; m_valid = 1'b0; pc_m = 32'h3020;
        @(negedge clk);
        total++; if (exc_req !== 1'b0) begin bad++; $display("FAIL bubble_no_take got %0b want 0", exc_req); end
        cyc(); m_valid = 1'b1; exccode_m = 5'd12;
        @(negedge clk);
        total++; if (exc_req !== 1'b1) begin bad++; $display("FAIL prio_take got %0b want 1", exc_req); end
        cyc(); idle(); cp0_addr = 5'd13;
        @(negedge clk);
        total++; if (cp0_rdata !== 32'h0000_0400) begin bad++; $display("FAIL prio_cause got %h want 400", cp0_rdata); end
        total++; if (epc_out !== 32'h3020) begin bad++; $display("FAIL prio_epc got %h want 3020", epc_out); end
        cyc(); cyc();
        m_valid = 1'b1; eret_m = 1'b1;
        cyc(); idle();
    endtask

    task automatic test_mtc0_drop();
        idle(); m_valid = 1'b1; exccode_m = 5'd10; pc_m = 32'h3040;
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h5000;
        cyc(); idle(); m_valid = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h6000;
        @(negedge clk);
        total++; if (epc_out !== 32'h3040) begin bad++; $display("FAIL drop_exc_epc got %h want 3040", epc_out); end
        cyc(); idle();
        @(negedge clk);
        total++; if (epc_out !== 32'h3040) begin bad++; $display("FAIL drop_flush_epc got %h want 3040", epc_out); end
        m_valid = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h7007;
        cyc(); idle(); m_valid = 1'b1; eret_m = 1'b1;
        @(negedge clk);
        total++; if (redirect_pc !== 32'h7004) begin bad++; $display("FAIL hdl_mtc0_epc got %h want 7004", redirect_pc); end
        cyc(); idle();
    endtask

    task automatic test_wrap_reset();
        idle(); m_valid = 1'b1; exccode_m = 5'd10; pc_m = 32'h0; bd_m = 1'b1;
        cyc(); idle();
        @(negedge clk);
        total++; if (epc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_epc got %h want fffffffc", epc_out); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL wrap_flush got %0b want 1", flush); end
        reset_n = 1'b0; #1;
        total++; if (flush !== 1'b0 || epc_out !== 32'h0) begin bad++; $display("FAIL async_rst got flush=%0b epc=%h want 0 0", flush, epc_out); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1800; n++) begin
            if (n % 300 == 299) do_reset();
            m_valid   = ($urandom_range(0, 99) < 85);
            exccode_m = ($urandom_range(0, 99) < 15) ? 5'($urandom_range(1, 31)) : 5'd0;
            hwint     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            pc_m      = ($urandom_range(0, 19) == 0) ? 32'h0 : $urandom;
            bd_m      = ($urandom_range(0, 9) < 3);
            eret_m    = ($urandom_range(0, 99) < 15);
            cp0_we    = ($urandom_range(0, 99) < 15);
            cp0_addr  = ($urandom_range(0, 9) < 3) ? 5'($urandom) : 5'($urandom_range(12, 15));
            cp0_wdata = $urandom;
            @(negedge clk);
            model_comb();
            total++; if (exc_req !== e_req) begin bad++; $display("FAIL rnd_exc_req n=%0d got %0b want %0b", n, exc_req, e_req); end
            total++; if (flush !== e_flush) begin bad++; $display("FAIL rnd_flush n=%0d got %0b want %0b", n, flush, e_flush); end
            total++; if (redirect !== e_redir) begin bad++; $display("FAIL rnd_redirect n=%0d got %0b want %0b", n, redirect, e_redir); end
            total++; if (redirect_pc !== e_rpc) begin bad++; $display("FAIL rnd_redirect_pc n=%0d got %h want %h", n, redirect_pc, e_rpc); end
            total++; if (epc_out !== m_epc) begin bad++; $display("FAIL rnd_epc n=%0d got %h want %h", n, epc_out, m_epc); end
            total++; if (cp0_rdata !== e_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d reg%0d got %h want %h", n, cp0_addr, cp0_rdata, e_rdata); end
            @(posedge clk);
            model_clock();
            #1;
        end
        idle();
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        test_reset();
        test_exception_eret();
        test_interrupt();
        test_priority_bubble();
        test_mtc0_drop();
        test_wrap_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
